// File: rtl/tile_rotate_buffer_if.sv
// Bus-side signal bundle for tile_rotate_buffer: sequencer handshake, pixel data and status.
// I_MIRROR exists only when ROT_BUF_MIRROR_EN is defined.
interface tile_rotate_buffer_if #(
  parameter int PIX_W = 24
);
  logic             I_START;
  logic             I_DMA_READY;
  logic             I_WRITE;
  logic [PIX_W-1:0] I_RDATA;
  logic             I_DIRECTION;
  logic [2:0]       I_DEGREES;
`ifdef ROT_BUF_MIRROR_EN
  logic             I_MIRROR;
`endif
  logic [PIX_W-1:0] O_WDATA;
  logic             O_VALID;
  logic             O_FULL;
  logic             O_OVERRUN;

  modport master (
    output I_START, I_DMA_READY, I_WRITE, I_RDATA, I_DIRECTION, I_DEGREES,
`ifdef ROT_BUF_MIRROR_EN
    output I_MIRROR,
`endif
    input  O_WDATA, O_VALID, O_FULL, O_OVERRUN
  );

  modport slave (
    input  I_START, I_DMA_READY, I_WRITE, I_RDATA, I_DIRECTION, I_DEGREES,
`ifdef ROT_BUF_MIRROR_EN
    input  I_MIRROR,
`endif
    output O_WDATA, O_VALID, O_FULL, O_OVERRUN
  );
endinterface

// File: rtl/tile_rotate_buffer.sv
// Captures an 8x8 pixel tile during READ beats and replays it rotated during WRITE beats.
// Optional ROT_BUF_MIRROR_EN adds a horizontal mirror applied before the rotation.
module tile_rotate_buffer #(
  parameter int PIX_W = 24
) (
  input  logic                 I_HCLK,
  input  logic                 I_HRESET_N,
  tile_rotate_buffer_if.slave  bus
);

  typedef enum logic [1:0] {FILL, PREP, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [5:0]       fill_cnt_q, fill_cnt_d;
  logic [5:0]       drain_cnt_q, drain_cnt_d;
  logic [1:0]       ang_q, ang_d;
  logic             mir_q, mir_d;
  logic [PIX_W-1:0] wdata_q, wdata_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             overrun_q, overrun_d;
  logic             wr_en;

  logic [PIX_W-1:0] mem [64];

  logic [1:0]       eff_ang;
  logic             eff_mir;
  logic [5:0]       rd_idx;
  logic [PIX_W-1:0] rd_pix;
  logic             read_beat;
  logic             consume_beat;

  // Output position k = (i,j) -> source index 8*row + col; mirror flips the source column.
  function automatic logic [5:0] map_idx(input logic [5:0] k, input logic [1:0] ang,
                                         input logic mir);
    logic [2:0] i, j, r, c;
    i = k[5:3];
    j = k[2:0];
    case (ang)
      2'd1:    begin r = 3'd7 - j; c = i;        end
      2'd2:    begin r = 3'd7 - i; c = 3'd7 - j; end
      2'd3:    begin r = j;        c = 3'd7 - i; end
      default: begin r = i;        c = j;        end
    endcase
    if (mir) c = 3'd7 - c;
    return {r, c};
  endfunction

  // Counter-clockwise by n is clockwise by (4-n) mod 4, which is a 2-bit negation.
  assign eff_ang = bus.I_DEGREES[2] ? 2'd0
                 : (bus.I_DIRECTION ? bus.I_DEGREES[1:0] : 2'd0 - bus.I_DEGREES[1:0]);
`ifdef ROT_BUF_MIRROR_EN
  assign eff_mir = bus.I_MIRROR;
`else
  assign eff_mir = 1'b0;
`endif

  assign read_beat    = bus.I_DMA_READY && !bus.I_WRITE;
  assign consume_beat = valid_q && bus.I_DMA_READY && bus.I_WRITE;
  assign rd_idx       = (state_q == PREP) ? map_idx(6'd0, eff_ang, eff_mir)
                                          : map_idx(drain_cnt_q + 6'd1, ang_q, mir_q);
  assign rd_pix       = mem[rd_idx];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    ang_d       = ang_q;
    mir_d       = mir_q;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    full_d      = full_q;
    overrun_d   = overrun_q;
    wr_en       = 1'b0;

    if (bus.I_START) begin
      state_d     = FILL;
      fill_cnt_d  = '0;
      drain_cnt_d = '0;
      valid_d     = 1'b0;
      full_d      = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (read_beat) begin
            wr_en      = 1'b1;
            fill_cnt_d = fill_cnt_q + 6'd1;
            if (fill_cnt_q == 6'd63) begin
              state_d = PREP;
              full_d  = 1'b1;
            end
          end
        end
        PREP: begin
          if (read_beat) overrun_d = 1'b1;
          ang_d   = eff_ang;
          mir_d   = eff_mir;
          wdata_d = rd_pix;
          valid_d = 1'b1;
          state_d = DRAIN;
        end
        DRAIN: begin
          if (read_beat) overrun_d = 1'b1;
          if (consume_beat) begin
            wdata_d     = rd_pix;
            drain_cnt_d = drain_cnt_q + 6'd1;
            if (drain_cnt_q == 6'd63) begin
              valid_d     = 1'b0;
              full_d      = 1'b0;
              drain_cnt_d = '0;
              fill_cnt_d  = '0;
              state_d     = FILL;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      ang_q       <= '0;
      mir_q       <= 1'b0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ang_q       <= ang_d;
      mir_q       <= mir_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      full_q      <= full_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: pixel storage has no reset; it is always written before it is read.
  always_ff @(posedge I_HCLK) begin
    if (wr_en) mem[fill_cnt_q] <= bus.I_RDATA;
  end

  assign bus.O_WDATA   = wdata_q;
  assign bus.O_VALID   = valid_q;
  assign bus.O_FULL    = full_q;
  assign bus.O_OVERRUN = overrun_q;

endmodule

// File: tb/tb_tile_rotate_buffer.sv
// Directed bench for tile_rotate_buffer: fills tiles with pixel value = index and checks drain order.
// Mirror case runs only when ROT_BUF_MIRROR_EN is defined.
module tb_tile_rotate_buffer;

  localparam int PIX_W = 24;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [PIX_W-1:0] outs [64];

  tile_rotate_buffer_if #(.PIX_W(PIX_W)) bus ();

  tile_rotate_buffer #(.PIX_W(PIX_W)) dut (
    .I_HCLK     (clk),
    .I_HRESET_N (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source index for output position k under the given clockwise angle and mirror.
  function automatic logic [31:0] exp_pix(input int k, input logic [1:0] ang, input bit mir);
    int i, j, r, c;
    i = k / 8;
    j = k % 8;
    case (ang)
      2'd1:    begin r = 7 - j; c = i;     end
      2'd2:    begin r = 7 - i; c = 7 - j; end
      2'd3:    begin r = j;     c = 7 - i; end
      default: begin r = i;     c = j;     end
    endcase
    if (mir) c = 7 - c;
    return 32'(r * 8 + c);
  endfunction

  task automatic set_angle(input bit dir, input logic [2:0] deg);
    bus.I_DIRECTION = dir;
    bus.I_DEGREES   = deg;
  endtask

  task automatic fill(input int count, input int first);
    for (int k = 0; k < count; k++) begin
      bus.I_DMA_READY = 1'b1;
      bus.I_WRITE     = 1'b0;
      bus.I_RDATA     = PIX_W'(first + k);
      tick();
    end
    bus.I_DMA_READY = 1'b0;
    bus.I_WRITE     = 1'b1;
  endtask

  // Full fill, then check the PREP cycle and the first valid cycle.
  task automatic fill_and_prep();
    fill(64, 0);
    check("prep_full", bus.O_FULL, 1);
    check("prep_valid_low", bus.O_VALID, 0);
    tick();
    check("drain_valid_rise", bus.O_VALID, 1);
  endtask

  task automatic drain(input logic [1:0] ang, input bit mir, input bit toggle,
                       input int change_at, input int inj_at);
    int n;
    int cyc;
    bit rdy;
    bit injected;
    n = 0;
    cyc = 0;
    injected = 1'b0;
    while (n < 64 && cyc < 400) begin
      check("drain_valid", bus.O_VALID, 1);
      check("drain_wdata", bus.O_WDATA, exp_pix(n, ang, mir));
      outs[n] = bus.O_WDATA;
      if (n == change_at) bus.I_DEGREES = 3'd3;
      if (!injected && n == inj_at) begin
        injected        = 1'b1;
        bus.I_DMA_READY = 1'b1;
        bus.I_WRITE     = 1'b0;
        bus.I_RDATA     = 24'hABCDEF;
        tick();
        bus.I_WRITE     = 1'b1;
        check("overrun_set", bus.O_OVERRUN, 1);
      end else begin
        rdy             = toggle ? (cyc % 2 == 0) : 1'b1;
        bus.I_DMA_READY = rdy;
        bus.I_WRITE     = 1'b1;
        tick();
        if (rdy) n++;
      end
      cyc++;
    end
    bus.I_DMA_READY = 1'b0;
    check("drain_beats", n, 64);
    check("drain_valid_fall", bus.O_VALID, 0);
    check("drain_full_fall", bus.O_FULL, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n           = 1'b0;
    bus.I_START     = 1'b0;
    bus.I_DMA_READY = 1'b0;
    bus.I_WRITE     = 1'b0;
    bus.I_RDATA     = '0;
    bus.I_DIRECTION = 1'b1;
    bus.I_DEGREES   = 3'd0;
`ifdef ROT_BUF_MIRROR_EN
    bus.I_MIRROR    = 1'b0;
`endif
    repeat (2) tick();
    check("rst_wdata", bus.O_WDATA, 0);
    check("rst_valid", bus.O_VALID, 0);
    check("rst_full", bus.O_FULL, 0);
    check("rst_overrun", bus.O_OVERRUN, 0);
    rst_n = 1'b1;
    tick();

    // Identity order.
    set_angle(1'b1, 3'd0);
    fill_and_prep();
    drain(2'd0, 1'b0, 1'b0, -1, -1);
    check("id_last", outs[63], 63);

    // 90 deg clockwise.
    set_angle(1'b1, 3'd1);
    fill_and_prep();
    drain(2'd1, 1'b0, 1'b0, -1, -1);
    check("cw90_0", outs[0], 56);
    check("cw90_1", outs[1], 48);
    check("cw90_8", outs[8], 57);
    check("cw90_last", outs[63], 7);

    // 90 deg counter-clockwise equals 270 clockwise.
    set_angle(1'b0, 3'd1);
    fill_and_prep();
    drain(2'd3, 1'b0, 1'b0, -1, -1);
    check("ccw90_0", outs[0], 7);
    check("ccw90_1", outs[1], 15);
    check("ccw90_7", outs[7], 63);
    check("ccw90_8", outs[8], 6);
    check("ccw90_last", outs[63], 56);

    // 180 deg.
    set_angle(1'b1, 3'd2);
    fill_and_prep();
    drain(2'd2, 1'b0, 1'b0, -1, -1);
    check("r180_0", outs[0], 63);
    check("r180_last", outs[63], 0);

    // Degrees 5 with CCW direction still means no rotation.
    set_angle(1'b0, 3'd5);
    fill_and_prep();
    drain(2'd0, 1'b0, 1'b0, -1, -1);
    check("deg5_9", outs[9], 9);

    // Ready toggling with an angle change mid-drain: held data, latched order.
    set_angle(1'b1, 3'd1);
    fill_and_prep();
    drain(2'd1, 1'b0, 1'b1, 20, -1);

    // Read beat during drain at 180 deg: pixel 0 is emitted last, so a stray write would show.
    set_angle(1'b1, 3'd2);
    fill_and_prep();
    drain(2'd2, 1'b0, 1'b0, -1, 10);
    check("overrun_sticky", bus.O_OVERRUN, 1);
    bus.I_START = 1'b1;
    tick();
    bus.I_START = 1'b0;
    check("start_overrun", bus.O_OVERRUN, 0);
    check("start_full", bus.O_FULL, 0);
    check("start_valid", bus.O_VALID, 0);

    // I_START beats a concurrent consume mid-drain, then mid-fill.
    set_angle(1'b1, 3'd0);
    fill_and_prep();
    bus.I_DMA_READY = 1'b1;
    bus.I_WRITE     = 1'b1;
    tick();
    tick();
    bus.I_START = 1'b1;
    tick();
    bus.I_START     = 1'b0;
    bus.I_DMA_READY = 1'b0;
    check("start_drain_valid", bus.O_VALID, 0);
    check("start_drain_full", bus.O_FULL, 0);
    fill(20, 100);
    bus.I_START = 1'b1;
    tick();
    bus.I_START = 1'b0;
    fill(63, 0);
    check("refill63_full", bus.O_FULL, 0);
    fill(1, 63);
    check("refill64_full", bus.O_FULL, 1);
    tick();
    check("refill_valid", bus.O_VALID, 1);
    drain(2'd0, 1'b0, 1'b0, -1, -1);

    // Asynchronous reset after 30 fill beats.
    fill(30, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_fill_valid", bus.O_VALID, 0);
    check("arst_fill_full", bus.O_FULL, 0);
    tick();
    rst_n = 1'b1;
    set_angle(1'b1, 3'd2);
    fill(63, 0);
    check("arst_refill63_full", bus.O_FULL, 0);
    check("arst_refill63_valid", bus.O_VALID, 0);
    fill(1, 63);
    check("arst_refill64_full", bus.O_FULL, 1);
    tick();
    check("arst_drain_valid", bus.O_VALID, 1);
    check("arst_drain_wdata", bus.O_WDATA, 63);

    // Asynchronous reset mid-drain takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_drain_valid_low", bus.O_VALID, 0);
    check("arst_drain_full_low", bus.O_FULL, 0);
    check("arst_drain_wdata_zero", bus.O_WDATA, 0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef ROT_BUF_MIRROR_EN
    set_angle(1'b1, 3'd0);
    bus.I_MIRROR = 1'b1;
    fill_and_prep();
    bus.I_MIRROR = 1'b0;
    drain(2'd0, 1'b1, 1'b0, -1, -1);
    check("mirror_0", outs[0], 7);
    check("mirror_7", outs[7], 0);
    check("mirror_8", outs[8], 15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
